mem: RTL and testbench

- Synchronous single-port RAM model; the memory side of the memory interface.
- Stores 2^AW words of DW bits.
- Accepts write and read strobes with an address from the test side and returns registered read data on data_out.
- The stimulus side drives inputs on the falling clock edge; the block acts only on rising edges.

---
 rtl/mem.sv | 26 ++
 tb/tb_mem.sv | 91 +++++++++
 2 files changed

// File: rtl/mem.sv
// mem: synchronous single-port RAM, 2^AW x DW, with registered read-before-write data_out.
// Reset clears both the output register and every storage word.
module mem #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] addr,
    input  logic          write,
    input  logic          read,
    output logic [DW-1:0] data_out
);
    logic [DW-1:0] mem_q [2**AW];
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_out <= '0;
            for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
        end else begin
            // Read samples the pre-edge word, so a same-cycle write is seen only later
            if (write) mem_q[addr] <= data_in;
            if (read) data_out <= mem_q[addr];
        end
    end
endmodule

// File: tb/tb_mem.sv
// tb_mem: directed and random steps against an array-based reference of the RAM.
module tb_mem;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] data_in = '0;
    logic [4:0] addr = '0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;
    bit known = 0;
    logic [7:0] model_mem [32];
    logic [7:0] exp_q = '0;

    mem #(.DW(8), .AW(5)) dut (
        .CLK(CLK), .RST(RST), .data_in(data_in), .addr(addr),
        .write(write), .read(read), .data_out(data_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input logic [7:0] want, input string tag);
        checks++;
        assert (data_out === want) else begin
            errors++;
            $error("FAIL %s: data_out=%h expected=%h", tag, data_out, want);
        end
    endtask

    task automatic step(input bit rst, input bit w, input bit r,
                        input logic [4:0] a, input logic [7:0] d, input string tag);
        @(negedge CLK);
        RST = rst; write = w; read = r; addr = a; data_in = d;
        @(posedge CLK);
        if (rst) begin
            exp_q = '0;
            foreach (model_mem[i]) model_mem[i] = '0;
        end else begin
            if (r) exp_q = model_mem[a];
            if (w) model_mem[a] = d;
        end
        #1;
        if (rst) known = 1;
        if (known) chk(exp_q, tag);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) step(0, 1, 0, 5'(i * 3), 8'($urandom), "prefill");
        step(1, 0, 0, 0, 0, "reset1");
        step(1, 0, 0, 0, 0, "reset2");
        chk(8'h00, "reset_out");
        for (int i = 0; i < 32; i++) step(0, 0, 1, 5'(i), 8'h55, "read_zero");
        step(0, 1, 0, 5'd5, 8'hA5, "wr5");
        step(0, 0, 1, 5'd5, 8'h00, "rd5");
        chk(8'hA5, "rd5_const");
        step(0, 0, 0, 5'd9, 8'h00, "hold1");
        step(0, 1, 0, 5'd5, 8'h5A, "hold_wr");
        chk(8'hA5, "hold_const");
        for (int i = 0; i < 32; i++) step(0, 1, 0, 5'(i), 8'(i), "fill");
        for (int i = 0; i < 32; i++) step(0, 0, 1, 5'(i), 8'h00, "fill_rd");
        chk(8'd31, "fill_last");
        for (int i = 0; i < 32; i++) step(0, 1, 0, 5'(i), 8'(8'hFF - i), "inv");
        for (int i = 0; i < 32; i++) step(0, 0, 1, 5'(i), 8'h00, "inv_rd");
        chk(8'hE0, "inv_last");
        step(0, 1, 0, 5'd3, 8'h11, "b2b_w3");
        step(0, 1, 0, 5'd4, 8'h22, "b2b_w4");
        step(0, 1, 0, 5'd5, 8'h33, "b2b_w5");
        step(0, 0, 1, 5'd3, 8'h00, "b2b_r3");
        chk(8'h11, "b2b_11");
        step(0, 0, 1, 5'd4, 8'h00, "b2b_r4");
        chk(8'h22, "b2b_22");
        step(0, 0, 1, 5'd5, 8'h00, "b2b_r5");
        chk(8'h33, "b2b_33");
        step(0, 1, 0, 5'd7, 8'h3C, "rw_pre");
        step(0, 1, 1, 5'd7, 8'hC3, "rw_same");
        chk(8'h3C, "rw_old");
        step(0, 0, 1, 5'd7, 8'h00, "rw_after");
        chk(8'hC3, "rw_new");
        step(1, 1, 1, 5'd9, 8'h77, "rst_wr");
        chk(8'h00, "rst_wr_out");
        step(0, 0, 1, 5'd9, 8'h00, "rst_rd9");
        chk(8'h00, "rst_rd9_const");
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom),
                 5'($urandom), 8'($urandom), "random");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
